conv_4_mul_arbiter: RTL and testbench
=====================================

# conv_4_mul_arbiter

Shares one signed 16x8 multiplier among `NUM_REQ` requesters in the conv_4 datapath. Requesters present operand pairs over valid/ready. A round-robin arbiter admits one pair per cycle into a two-stage pipeline: operand register, then product register. Each 24-bit product leaves on a single valid/ready output port, tagged with the requester index, so one DSP slice serves all conv_4 filter lanes.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester tag.

Ports:
- `ap_clk` in 1: single clock. All logic is on its rising edge.
- `ap_rst` in 1: reset, synchronous and active-high.
- `req_valid` in `NUM_REQ`: per-requester operand valid.
- `req_ready` out `NUM_REQ`: per-requester accept. At most one bit is high.
- `req_din0` in `NUM_REQ*16`: signed 16-bit operand A per requester. Requester i occupies bits [16i+15:16i].
- `req_din1` in `NUM_REQ*8`: signed 8-bit operand B per requester. Requester i occupies bits [8i+7:8i].
- `out_valid` out 1: product valid.
- `out_ready` in 1: downstream accept.
- `out_dout` out 24: signed product.
- `out_id` out `ID_W`: index of the requester that issued the product.
- `stat_count` out 32: count of products accepted downstream. Wraps modulo 2^32.

## Operation
- Handshake: a transfer occurs on a cycle where valid and ready are both high.
  - Once a requester raises `req_valid`, it holds `req_valid` and its operands stable until accepted.
  - `req_valid` must not depend on `req_ready`.
- Pipeline advance:
  - `p_adv = !p_valid || out_ready`.
  - `a_adv = !a_valid || p_adv`.
- Arbitration is combinational from `req_valid` and `rr_ptr`:
  - `grant` is one-hot at the first valid index, searching from `rr_ptr` upward and wrapping past `NUM_REQ-1` to 0.
  - `req_ready = grant & {NUM_REQ{a_adv}}`.
- Accept of index k:
  - Stage A captures din0, din1 and tag k.
  - `rr_ptr <= (k+1) mod NUM_REQ`.
  - With no accept, `rr_ptr` holds.
- Stage A to P, when `p_adv`:
  - `p_dout <= $signed(a_din0) * $signed(a_din1)`, full 24-bit result with no truncation or saturation.
  - `p_id <= a_id`, `p_valid <= a_valid`.
- Outputs: `out_valid`, `out_dout` and `out_id` are driven directly from stage P.
- Stall: with `out_valid && !out_ready`, both stages hold and at most one new pair is admitted, to fill an empty stage A.
- Counter: `stat_count` increments by 1 on each `out_valid && out_ready`.
- Range: -32768 * -128 = 4194304 fits in 24-bit signed, so there is no overflow case.

## Timing
- Reset values:
  - `req_ready` = 0 during reset.
  - `out_valid` = 0, `out_dout` = 0, `out_id` = 0, `stat_count` = 0.
  - `rr_ptr` = 0, all stage valids = 0.
- Reset mid-operation: both in-flight products are discarded and no output handshake completes. The first cycle after reset deassertion admits normally.
- Latency: accept at cycle t gives `out_valid` at t+2 with no backpressure.
- Throughput: 1 product per cycle with `out_ready` held high.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,…. A waiting requester is served within `NUM_REQ` accepts.
- Simultaneous events:
  - Output accept and new admit in the same cycle are both performed, with no bubble.
  - A counter increment and a reset in the same cycle resolve to reset.
- Full: both stages valid and `out_ready`=0 gives all `req_ready` = 0.
- Empty: with no `req_valid`, `out_valid` drops 2 cycles after the last admit.

## Structure
- Shared package `conv_4_mul_pkg`:
  - Constants `MUL_A_W=16`, `MUL_B_W=8`, `MUL_P_W=24`.
  - Typedef for the stage A struct {din0, din1, id, valid}.
- Sub-module `conv_4_mul_rr_pick`: purely combinational round-robin picker.
  - Inputs: `req`, `ptr`.
  - Outputs: `grant` (one-hot), `grant_idx`, `any`.
- The multiply is inferred in stage P and must map to one DSP48.

## Test plan
- Single request: requester 2 with din0=300, din1=-5 at cycle 0 gives `out_valid` at cycle 2 with dout=-1500 and id=2. `stat_count` reads 1.
- Extremes: (-32768, -128) gives 4194304; (32767, -128) gives -4194176; (0, 77) gives 0.
- Fairness: all 4 requesters valid for 12 cycles with `out_ready`=1 gives ids 0,1,2,3 repeated 3 times, back-to-back.
- Backpressure: `out_ready`=0 for 5 cycles under full load.
  - Exactly 2 pairs are admitted and `req_ready` then stays 0.
  - The output holds stable.
  - On release there is no loss or duplication; the ids in order match the ids admitted.
- Reset mid-flight: assert `ap_rst` with both stages valid.
  - The next cycle shows `out_valid`=0, `stat_count`=0 and `rr_ptr`=0.
  - The first grant after reset goes to the lowest valid index.
- Random soak: 10k random valids, operands and `out_ready`. Every product matches a scoreboard keyed by id, and `stat_count` equals the number of output handshakes.

Source files
------------

// File: rtl/conv_4_mul_pkg.sv
// conv_4_mul_pkg: shared widths and stage-A record for the conv_4 shared multiplier.
package conv_4_mul_pkg;
    localparam int MUL_A_W = 16;
    localparam int MUL_B_W = 8;
    localparam int MUL_P_W = 24;
    localparam int MUL_ID_MAX_W = 4;

    typedef struct packed {
        logic signed [MUL_A_W-1:0] din0;
        logic signed [MUL_B_W-1:0] din1;
        logic [MUL_ID_MAX_W-1:0]   id;
        logic                      valid;
    } mul_stage_a_t;
endpackage

// File: rtl/conv_4_mul_rr_pick.sv
// conv_4_mul_rr_pick: combinational round-robin pick of the first set bit at or above ptr, wrapping.
module conv_4_mul_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);
    always_comb begin
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N]) grant_idx = IW'((int'(ptr) + i) % N);
    end

    assign any   = |req;
    assign grant = any ? N'(1) << grant_idx : '0;
endmodule

// File: rtl/conv_4_mul_arbiter.sv
// conv_4_mul_arbiter: round-robin sharing of one signed 16x8 multiplier across NUM_REQ requesters.
module conv_4_mul_arbiter
    import conv_4_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*MUL_A_W-1:0]   req_din0,
    input  logic [NUM_REQ*MUL_B_W-1:0]   req_din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [MUL_P_W-1:0]           out_dout,
    output logic [ID_W-1:0]              out_id,
    output logic [31:0]                  stat_count
);
    mul_stage_a_t        a_q, a_d;
    logic                p_valid_q;
    logic [MUL_P_W-1:0]  p_dout_q;
    logic [ID_W-1:0]     p_id_q;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [31:0]         stat_q;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                any, p_adv, a_adv, a_open, accept;

    conv_4_mul_rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    assign p_adv     = !p_valid_q || out_ready;
    assign a_adv     = !a_q.valid || p_adv;
    assign a_open    = a_adv && !ap_rst;
    assign accept    = any && a_open;
    assign req_ready = grant & {NUM_REQ{a_open}};
    assign rr_ptr_d  = accept ? (grant_idx == ID_W'(NUM_REQ - 1) ? '0 : grant_idx + 1'b1) : rr_ptr_q;

    always_comb begin
        a_d       = a_q;
        a_d.valid = a_q.valid && !p_adv;
        if (accept) begin
            a_d.din0  = req_din0[int'(grant_idx)*MUL_A_W +: MUL_A_W];
            a_d.din1  = req_din1[int'(grant_idx)*MUL_B_W +: MUL_B_W];
            a_d.id    = MUL_ID_MAX_W'(grant_idx);
            a_d.valid = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            a_q       <= '0;
            p_valid_q <= 1'b0;
            p_dout_q  <= '0;
            p_id_q    <= '0;
            rr_ptr_q  <= '0;
            stat_q    <= '0;
        end else begin
            a_q      <= a_d;
            rr_ptr_q <= rr_ptr_d;
            if (p_adv) begin
                p_valid_q <= a_q.valid;
                p_dout_q  <= MUL_P_W'(a_q.din0) * MUL_P_W'(a_q.din1);
                // stage A carries a max-width tag; fold it back to this instance's tag width
                p_id_q    <= ID_W'(int'(a_q.id) % NUM_REQ);
            end
            if (out_valid && out_ready) stat_q <= stat_q + 32'd1;
        end
    end

    // masked during reset so an in-flight product can never complete a handshake
    assign out_valid  = p_valid_q && !ap_rst;
    assign out_dout   = p_dout_q;
    assign out_id     = p_id_q;
    assign stat_count = stat_q;
endmodule

// File: tb/tb_conv_4_mul_arbiter.sv
// tb_conv_4_mul_arbiter: directed and random-soak checks of the shared multiplier arbiter.
module tb_conv_4_mul_arbiter;
    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [3:0]  req_valid, req_ready;
    logic [63:0] req_din0;
    logic [31:0] req_din1;
    logic        out_valid, out_ready;
    logic [23:0] out_dout;
    logic [1:0]  out_id;
    logic [31:0] stat_count;
    int          checks = 0;
    int          errors = 0;

    conv_4_mul_arbiter dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_din0   (req_din0),
        .req_din1   (req_din1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dout   (out_dout),
        .out_id     (out_id),
        .stat_count (stat_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic next();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic logic [31:0] prod(input int a, input int b);
        return 32'(a * b);
    endfunction

    function automatic logic [31:0] sx(input logic [23:0] v);
        return {{8{v[23]}}, v};
    endfunction

    task automatic set_op(input int k, input int a, input int b);
        req_din0[k*16 +: 16] = 16'(a);
        req_din1[k*8 +: 8]   = 8'(b);
    endtask

    task automatic single(input int k, input int a, input int b);
        req_valid = 4'(1 << k);
        set_op(k, a, b);
        out_ready = 1'b1;
        #4 chk("single_ready", 32'(req_ready), 32'(1 << k));
        next();
        req_valid = '0;
        #4 chk("single_t1_valid", 32'(out_valid), 0);
        next();
        #4;
        chk("single_t2_valid", 32'(out_valid), 1);
        chk("single_dout", sx(out_dout), prod(a, b));
        chk("single_id", 32'(out_id), 32'(k));
        next();
    endtask

    logic [3:0]  acc;
    int          qid[$];
    logic [31:0] qp[$];
    int          hs, admits;

    initial begin
        ap_rst = 1'b1; req_valid = 4'hF; out_ready = 1'b1; req_din0 = '0; req_din1 = '0;
        next();
        #4 chk("rst_ready_0", 32'(req_ready), 0);
        next();
        #4;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_dout", 32'(out_dout), 0);
        chk("rst_id", 32'(out_id), 0);
        chk("rst_stat", stat_count, 0);
        chk("rst_ready_1", 32'(req_ready), 0);
        ap_rst = 1'b0; req_valid = '0;
        next();

        single(2, 300, -5);
        #4 chk("single_stat", stat_count, 1);
        next();
        single(1, -32768, -128);
        single(0, 32767, -128);
        single(3, 0, 77);

        for (int i = 0; i < 4; i++) set_op(i, 1000 * i - 1500, 13 * i - 20);
        for (int c = 0; c < 14; c++) begin
            req_valid = c < 12 ? 4'hF : 4'h0;
            out_ready = 1'b1;
            #4;
            if (c < 12) chk("fair_grant", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 2) begin
                chk("fair_valid", 32'(out_valid), 1);
                chk("fair_id", 32'(out_id), 32'((c - 2) % 4));
                chk("fair_dout", sx(out_dout), prod(1000 * ((c - 2) % 4) - 1500, 13 * ((c - 2) % 4) - 20));
            end
            next();
        end
        #4 chk("fair_stat", stat_count, 16);
        next();

        admits = 0;
        req_valid = 4'hF; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #4;
            admits += $countones(req_ready & req_valid);
            if (c >= 2) begin
                chk("bp_ready", 32'(req_ready), 0);
                chk("bp_valid", 32'(out_valid), 1);
                chk("bp_id_hold", 32'(out_id), 0);
                chk("bp_dout_hold", sx(out_dout), prod(-1500, -20));
            end
            next();
        end
        chk("bp_admits", 32'(admits), 2);
        req_valid = '0; out_ready = 1'b1;
        #4;
        chk("bp_rel0_valid", 32'(out_valid), 1);
        chk("bp_rel0_id", 32'(out_id), 0);
        next();
        #4;
        chk("bp_rel1_valid", 32'(out_valid), 1);
        chk("bp_rel1_id", 32'(out_id), 1);
        chk("bp_rel1_dout", sx(out_dout), prod(-500, -7));
        next();
        #4;
        chk("bp_rel2_valid", 32'(out_valid), 0);
        chk("bp_stat", stat_count, 18);
        next();

        req_valid = 4'b0110; out_ready = 1'b0;
        #4 chk("mid_grant0", 32'(req_ready), 32'h4);
        next();
        #4 chk("mid_grant1", 32'(req_ready), 32'h2);
        next();
        #4;
        chk("mid_full_valid", 32'(out_valid), 1);
        chk("mid_full_ready", 32'(req_ready), 0);
        next();
        ap_rst = 1'b1; out_ready = 1'b1;
        #4;
        chk("mid_rst_ready", 32'(req_ready), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        next();
        ap_rst = 1'b0; req_valid = 4'b1010;
        #4;
        chk("post_rst_valid", 32'(out_valid), 0);
        chk("post_rst_stat", stat_count, 0);
        chk("post_rst_grant", 32'(req_ready), 32'h2);
        next();

        ap_rst = 1'b1; req_valid = '0;
        next();
        ap_rst = 1'b0; hs = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    set_op(i, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 255)) - 128);
                end
            out_ready = $urandom_range(0, 3) != 0;
            #4;
            chk("soak_onehot", 32'($countones(req_ready) <= 1), 1);
            acc = req_ready & req_valid;
            for (int i = 0; i < 4; i++)
                if (acc[i]) begin
                    qid.push_back(i);
                    qp.push_back(prod(int'($signed(req_din0[i*16 +: 16])), int'($signed(req_din1[i*8 +: 8]))));
                end
            if (out_valid && out_ready) begin
                if (qid.size() == 0) chk("soak_unexpected_out", 32'(out_id), 32'hFFFF_FFFF);
                else begin
                    chk("soak_id", 32'(out_id), 32'(qid.pop_front()));
                    chk("soak_dout", sx(out_dout), qp.pop_front());
                    hs++;
                end
            end
            next();
            req_valid = req_valid & ~acc;
        end
        req_valid = '0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #4;
            if (out_valid) begin
                if (qid.size() == 0) chk("drain_unexpected_out", 32'(out_id), 32'hFFFF_FFFF);
                else begin
                    chk("drain_id", 32'(out_id), 32'(qid.pop_front()));
                    chk("drain_dout", sx(out_dout), qp.pop_front());
                    hs++;
                end
            end
            next();
        end
        chk("soak_queue_empty", 32'(qid.size()), 0);
        chk("soak_stat", stat_count, 32'(hs));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
